// File: rtl/data_mem_unit.sv
// Data memory stage: RV32I byte/half/word loads and stores behind a req/ready
// handshake with a fixed number of wait states before each access.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic          r_we;
  logic [2:0]    r_f3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;

  // Contents survive reset; only the power-on value is defined.
  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  // Upper address bits select nothing: the address space wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  logic illegal;
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr[0];
      3'b010:         illegal = |addr[1:0];
      default:        illegal = 1'b1;
    endcase
    if (we && funct3[2]) illegal = 1'b1;
  end

  logic [AW-1:0] widx;
  logic [31:0]   shifted, load_val, wd;
  logic [3:0]    be;
  always_comb begin
    widx    = r_addr[AW+1:2];
    shifted = mem[widx] >> {r_addr[1:0], 3'b000};
    case (r_f3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    wd = r_wdata << {r_addr[1:0], 3'b000};
    case (r_f3[1:0])
      2'b00:   be = 4'b0001 << r_addr[1:0];
      2'b01:   be = 4'b0011 << {r_addr[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ACCESS && r_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_f3    <= funct3;
            r_addr  <= addr[AW+1:0];
            r_wdata <= wdata;
            busy    <= 1'b1;
            if (illegal) begin
              state <= RESP;
              ready <= 1'b1;
              err   <= 1'b1;
              if (!we) rdata <= '0;
            end else if (LATENCY == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ACCESS;
        end
        ACCESS: begin
          if (!r_we) rdata <= load_val;
          state <= RESP;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: LATENCY=2 and LATENCY=0 instances checked against a
// byte-array reference model, with directed vectors and random traffic.
module tb_data_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, we, sel;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req2, req0;
  logic [31:0] rdata2, rdata0, o_rdata;
  logic        ready2, busy2, err2, ready0, busy0, err0;
  logic        o_ready, o_busy, o_err;

  assign req2    = req & ~sel;
  assign req0    = req & sel;
  assign o_rdata = sel ? rdata0 : rdata2;
  assign o_ready = sel ? ready0 : ready2;
  assign o_busy  = sel ? busy0  : busy2;
  assign o_err   = sel ? err0   : err2;

  data_mem_unit #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata2), .ready(ready2),
    .busy(busy2), .err(err2)
  );

  data_mem_unit #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0),
    .busy(busy0), .err(err0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed memory of 256 bytes per instance.
  logic [7:0]  mm [2][256];
  logic [31:0] mr [2];

  function automatic bit m_illegal(input bit w, input logic [2:0] f, input logic [31:0] a);
    case (f)
      3'd0:    return 1'b0;
      3'd1:    return a % 2 != 0;
      3'd2:    return a % 4 != 0;
      3'd4:    return w;
      3'd5:    return w || (a % 2 != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic m_apply(input int s, input bit w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, output bit e);
    int n;
    logic [31:0] v, t;
    e = m_illegal(w, f, a);
    n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    if (e) begin
      if (!w) mr[s] = 0;
    end else if (w) begin
      for (int k = 0; k < n; k++) begin
        t = d >> (8 * k);
        mm[s][(a + k) % 256] = t[7:0];
      end
    end else begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (32'(mm[s][(a + k) % 256]) << (8 * k));
      if (f == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (f == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      mr[s] = v;
    end
  endtask

  task automatic txn(input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input bit pulse,
                     output logic [31:0] r, output logic e, output int lat,
                     output logic bz_resp, output logic bz_after);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (o_ready) begin
        lat = n;
        break;
      end
      if (pulse && n < 3) begin
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h44; wdata = '1;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    r = o_rdata;
    e = o_err;
    bz_resp = o_busy;
    @(posedge clk); #1;
    bz_after = o_busy;
  endtask

  task automatic run(input string name, input bit w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d, input bit pulse,
                     input bit has_exp, input logic [31:0] exp_r, input bit exp_e);
    logic [31:0] r;
    logic e, bz1, bz2;
    int lat, explat;
    bit me;
    int s;
    s = sel ? 1 : 0;
    txn(w, f, a, d, pulse, r, e, lat, bz1, bz2);
    m_apply(s, w, f, a, d, me);
    explat = me ? 1 : (sel ? 2 : 4);
    check({name, " latency"}, lat, explat);
    check({name, " err"}, {31'b0, e}, {31'b0, me});
    check({name, " rdata"}, r, mr[s]);
    check({name, " busy_resp"}, {31'b0, bz1}, 32'd1);
    check({name, " busy_idle"}, {31'b0, bz2}, 32'd0);
    if (has_exp) begin
      check({name, " rdata_vec"}, r, exp_r);
      check({name, " err_vec"}, {31'b0, e}, {31'b0, exp_e});
    end
  endtask

  typedef struct {
    bit          w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tbl[$];
  logic [2:0] fsel [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

  initial begin
    for (int s = 0; s < 2; s++) begin
      mr[s] = 0;
      for (int i = 0; i < 256; i++) mm[s][i] = 8'h00;
    end
    tbl.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b1, 3'b000, 32'h11, 32'h12345678, 32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD78EF, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 32'h12, 32'hAAAA5555, 32'hDEAD78EF, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'h555578EF, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h02, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h00000000, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 32'h21, 32'h11112222, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0});
    tbl.push_back('{1'b0, 3'b011, 32'h00, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b100, 32'h30, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFFCAFE, 1'b0});

    reset = 1'b0; req = 1'b0; we = 1'b0; sel = 1'b0;
    funct3 = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst rdata2", rdata2, 32'h0);
    check("rst flags2", {29'b0, ready2, busy2, err2}, 32'h0);
    check("rst rdata0", rdata0, 32'h0);
    check("rst flags0", {29'b0, ready0, busy0, err0}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i])
      run($sformatf("vec%0d", i), tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].d, 1'b0,
          1'b1, tbl[i].er, tbl[i].ee);

    // Reset during WAIT aborts the store
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h1;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort busy_wait", {31'b0, busy2}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort rdata", rdata2, 32'h0);
    check("abort flags", {29'b0, ready2, busy2, err2}, 32'h0);
    mr[0] = 0; mr[1] = 0;
    @(negedge clk);
    reset = 1'b1;
    run("abort readback", 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

    // req pulses while busy must neither restart nor queue a transaction
    run("busy pulse", 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b1, 32'h555578EF, 1'b0);
    run("pulse ignored", 1'b0, 3'b010, 32'h44, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);

    // LATENCY=0 instance: address wrap then random traffic
    sel = 1'b1;
    run("wrap sw", 1'b1, 3'b010, 32'h100, 32'h13572468, 1'b0, 1'b1, 32'h0, 1'b0);
    run("wrap lw", 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b1, 32'h13572468, 1'b0);

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int i = 0; i < 80; i++) begin
        bit          w;
        logic [2:0]  f;
        logic [31:0] a;
        w = 1'($urandom_range(0, 1));
        f = fsel[$urandom_range(0, 9)];
        a = 32'($urandom_range(0, 511));
        if ($urandom_range(0, 3) != 0) begin
          if (f == 3'd2) a = a & ~32'd3;
          else if (f == 3'd1 || f == 3'd5) a = a & ~32'd1;
        end
        run($sformatf("rnd%0d_%0d", s, i), w, f, a, $urandom, 1'b0, 1'b0, 32'h0, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
